fp16_log_to_code_search: RTL and testbench

//  Inverse of the 256-entry 8b-code -> fp16 log table: takes an fp16 log-domain value and returns
//  the 8-bit code whose table entry is the largest one <= the input (floor search).
//  Bit-serial successive approximation over the monotone table, 8 compare cycles per request.

---
 rtl/fp16_log_to_code_search_pkg.sv | 48 ++++
 rtl/fp16_log_to_code_search_rom.sv | 20 ++
 rtl/fp16_log_to_code_search.sv | 95 +++++++++
 tb/tb_fp16_log_to_code_search.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_log_to_code_search_pkg.sv
// Shared constants, FSM encoding and the log-table generator for the fp16 log -> code search.
// Table entry c is fp16(ln(1 + c/2**cw)), round-to-nearest-even, fixed when the design is elaborated.
package fp16_log_to_code_search_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int CODE_WIDTH  = 8;
  localparam int EXPONENT    = 5;
  localparam int MANTISSA    = 10;
  localparam int EXP_BIAS    = 15;
  localparam int LN_FRAC     = 60;
  localparam logic [EXPONENT-1:0] FP16_EXP_ALL_ONES = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // ln(1+y) = 2*atanh(z), z = c/(2*2**cw + c) <= 1/3, summed in 60-bit fixed point.
  function automatic logic [DATA_WIDTH-1:0] log_entry(input int unsigned c, input int unsigned cw);
    logic [127:0] z, z2, term, sum, v, m, rem, half;
    int p, e, sh;
    if (c == 0) return '0;
    z    = (128'(c) << LN_FRAC) / 128'((2 << cw) + c);
    z2   = (z * z) >> LN_FRAC;
    term = z;
    sum  = '0;
    for (int n = 1; n < 80; n += 2) begin
      sum  = sum + term / 128'(n);
      term = (term * z2) >> LN_FRAC;
    end
    v = sum << 1;
    p = 0;
    for (int i = 0; i < 128; i++) if (v[i]) p = i;
    sh   = p - MANTISSA;
    m    = v >> sh;
    rem  = v & ((128'd1 << sh) - 128'd1);
    half = 128'd1 << (sh - 1);
    if (rem > half || (rem == half && m[0])) m = m + 128'd1;
    e = p - LN_FRAC;
    if (m[MANTISSA+1]) begin
      m = m >> 1;
      e = e + 1;
    end
    return {1'b0, 5'(e + EXP_BIAS), m[MANTISSA-1:0]};
  endfunction

endpackage

// File: rtl/fp16_log_to_code_search_rom.sv
// Combinational code -> fp16 log table; contents are elaboration-time constants.
module log_table_rom #(
  parameter int CODE_WIDTH = fp16_log_to_code_search_pkg::CODE_WIDTH,
  parameter int DATA_WIDTH = fp16_log_to_code_search_pkg::DATA_WIDTH
) (
  input  logic [CODE_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);
  import fp16_log_to_code_search_pkg::*;

  logic [DATA_WIDTH-1:0] rom [2**CODE_WIDTH];

  for (genvar i = 0; i < 2**CODE_WIDTH; i++) begin : g_entry
    localparam logic [DATA_WIDTH-1:0] ENTRY = log_entry(i, CODE_WIDTH);
    assign rom[i] = ENTRY;
  end

  assign data = rom[addr];

endmodule

// File: rtl/fp16_log_to_code_search.sv
// Floor search of an fp16 log value over the monotone log table: one code bit per cycle, MSB first.
// One request in flight; the result is held until the consumer takes it.
module fp16_log_to_code_search #(
  parameter int DATA_WIDTH = fp16_log_to_code_search_pkg::DATA_WIDTH,
  parameter int CODE_WIDTH = fp16_log_to_code_search_pkg::CODE_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_log,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CODE_WIDTH-1:0] out_code,
  output logic                  out_exact,
  output logic                  out_special
);
  import fp16_log_to_code_search_pkg::*;

  localparam int KW = $clog2(CODE_WIDTH);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] x_q, rom_data;
  logic [CODE_WIDTH-1:0] code_q, trial;
  logic [KW-1:0]         k_q;
  logic                  ready_q, special_q, exact_q, eq_q;
  logic                  le, hit, load, last;

  assign trial = code_q | (CODE_WIDTH'(1) << k_q);

  log_table_rom #(.CODE_WIDTH(CODE_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rom (
    .addr (trial),
    .data (rom_data)
  );

  // Every entry is a positive fp16, so ordering is plain unsigned ordering of the bit patterns.
  assign le   = rom_data <= x_q;
  assign hit  = rom_data == x_q;
  assign load = (state_q == ST_IDLE) && in_valid && ready_q;
  assign last = (state_q == ST_SEARCH) && (k_q == '0);

  // NOTE: give every always_comb output a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load) state_d = ST_SEARCH;
      ST_SEARCH: if (k_q == '0) state_d = ST_DONE;
      ST_DONE:   if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      x_q       <= '0;
      code_q    <= '0;
      k_q       <= '0;
      special_q <= 1'b0;
      exact_q   <= 1'b0;
      eq_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
      if (load) begin
        x_q       <= in_log[DATA_WIDTH-1] ? '0 : in_log;
        code_q    <= '0;
        k_q       <= KW'(CODE_WIDTH - 1);
        special_q <= (in_log[MANTISSA +: EXPONENT] == FP16_EXP_ALL_ONES);
        exact_q   <= 1'b0;
        // table[0] is +0: matches +0 and -0 only; other negatives clamp to code 0 inexactly.
        eq_q      <= (in_log[DATA_WIDTH-2:0] == '0);
      end else if (state_q == ST_SEARCH) begin
        k_q <= k_q - KW'(1);
        if (le) begin
          code_q <= trial;
          eq_q   <= hit;
        end
        if (last) begin
          exact_q <= !special_q && (le ? hit : eq_q);
          if (special_q) code_q <= '1;
        end
      end
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = (state_q == ST_DONE);
  assign out_code    = code_q;
  assign out_exact   = exact_q;
  assign out_special = special_q;

endmodule

// File: tb/tb_fp16_log_to_code_search.sv
// Self-checking bench: directed vector table, handshake/reset sequences, and a random sweep
// against a table-scan reference built from ln() in real arithmetic.
module tb_fp16_log_to_code_search;

  logic        clk = 1'b0;
  logic        resetn, in_valid, in_ready, out_valid, out_ready, out_exact, out_special;
  logic [15:0] in_log;
  logic [7:0]  out_code;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] tbl [256];

  fp16_log_to_code_search dut (
    .clk (clk), .resetn (resetn), .in_valid (in_valid), .in_ready (in_ready),
    .in_log (in_log), .out_valid (out_valid), .out_ready (out_ready),
    .out_code (out_code), .out_exact (out_exact), .out_special (out_special)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [7:0]  code;
    logic        exact;
    logic        special;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] to_fp16(input real v);
    real p = 0.5;
    int  e = -1;
    real scaled, frac;
    int  mi;
    while (v < p) begin
      p = p / 2.0;
      e--;
    end
    scaled = v / p * 1024.0;
    mi     = $rtoi(scaled);
    frac   = scaled - mi;
    if (frac > 0.5 || (frac == 0.5 && mi % 2 == 1)) mi++;
    if (mi == 2048) begin
      mi = 1024;
      e++;
    end
    return {1'b0, 5'(e + 15), 10'(mi - 1024)};
  endfunction

  function automatic void model(input logic [15:0] x, output logic [7:0] code,
                                output logic exact, output logic special);
    logic [15:0] xx;
    special = (x[14:10] == 5'h1F);
    xx      = x[15] ? 16'h0000 : x;
    code    = 8'd0;
    for (int c = 0; c < 256; c++) if (tbl[c] <= xx) code = 8'(c);
    exact = (tbl[code] == xx) && !(x[15] && x[14:0] != 15'd0);
    if (special) begin
      code  = 8'hFF;
      exact = 1'b0;
    end
  endfunction

  task automatic launch(input logic [15:0] x);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("launch_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_log   = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_log   = 16'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input string name, input logic [15:0] x, input logic [7:0] code,
                         input logic exact, input logic special);
    int lat;
    launch(x);
    wait_result(lat);
    check({name, "_latency"}, lat, 9);
    check({name, "_code"}, out_code, code);
    check({name, "_exact"}, out_exact, exact);
    check({name, "_special"}, out_special, special);
    accept();
  endtask

  initial begin
    vec_t vecs [10];
    int   lat;
    bit   leaked;
    logic [7:0]  m_code;
    logic        m_exact, m_special;
    logic [15:0] x;

    for (int c = 0; c < 256; c++) tbl[c] = (c == 0) ? 16'h0000 : to_fp16($ln(1.0 + c / 256.0));

    vecs[0] = '{16'h1BFC, 8'd1,   1'b1, 1'b0};
    vecs[1] = '{16'h2000, 8'd2,   1'b0, 1'b0};
    vecs[2] = '{16'h367D, 8'd128, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 8'd0,   1'b1, 1'b0};
    vecs[4] = '{16'h8123, 8'd0,   1'b0, 1'b0};
    vecs[5] = '{16'h7C00, 8'hFF,  1'b0, 1'b1};
    vecs[6] = '{16'h8000, 8'd0,   1'b1, 1'b0};
    vecs[7] = '{16'h1FF8, 8'd2,   1'b1, 1'b0};
    vecs[8] = '{16'h21F7, 8'd3,   1'b1, 1'b0};
    vecs[9] = '{16'hFFFF, 8'hFF,  1'b0, 1'b1};

    resetn = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_log = 16'h0000;
    #2 resetn = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_code", out_code, 0);
    check("rst_out_exact", out_exact, 0);
    check("rst_out_special", out_special, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].x, vecs[i].code, vecs[i].exact, vecs[i].special);

    // Back-pressure with a second request held on in_valid the whole time.
    @(negedge clk);
    in_valid = 1'b1;
    in_log   = 16'h1BFC;
    @(posedge clk);
    #1 in_log = 16'h21F7;
    wait_result(lat);
    check("bp_latency", lat, 9);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_code", out_code, 1);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    accept();
    @(negedge clk);
    check("bp_after_out_valid", out_valid, 0);
    check("bp_after_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(lat);
    check("bp2_latency", lat, 9);
    check("bp2_code", out_code, 3);
    check("bp2_exact", out_exact, 1);
    accept();

    // Reset during the fourth search cycle aborts the request.
    launch(16'h367D);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_code", out_code, 0);
    check("abort_out_exact", out_exact, 0);
    check("abort_out_special", out_special, 0);
    check("abort_in_ready", in_ready, 0);
    @(negedge clk);
    resetn = 1'b1;
    leaked = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) leaked = 1'b1;
    end
    check("abort_no_out_valid", leaked, 0);
    run_vec("post_abort", 16'h1FF8, 8'd2, 1'b1, 1'b0);

    // Every table entry, then random values around and between entries.
    for (int c = 0; c < 256; c++) begin
      model(tbl[c], m_code, m_exact, m_special);
      run_vec($sformatf("entry%0d", c), tbl[c], m_code, m_exact, m_special);
    end
    for (int i = 0; i < 300; i++) begin
      int c   = $urandom_range(0, 255);
      int sel = $urandom_range(0, 3);
      case (sel)
        0:       x = tbl[c];
        1:       x = (c < 255) ? tbl[c] + 16'd1 : tbl[c];
        2:       x = (c > 0) ? tbl[c] - 16'd1 : tbl[c];
        default: x = 16'($urandom);
      endcase
      model(x, m_code, m_exact, m_special);
      run_vec($sformatf("rand%0d_x%04h", i, x), x, m_code, m_exact, m_special);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
